simon_input_capture: RTL and testbench
======================================

# simon_input_capture

Parametrised button-capture engine for the Simon game datapath. It sits between the debounced button edge detectors (`pressed`/`released` one-cycle strobes) and the game controller. On request it arms, latches the highest-priority pressed button, and reports the press and the matching release as one-cycle strobes. Over the earlier fixed four-button capture it adds a configurable button count, an arm/abort handshake, a press timeout and a hold-duration measurement.

## Interface
Parameters:
- `N_BUTTONS`, 4: number of buttons; must be ≥ 2.
- `TIMEOUT_CYCLES`, 1000: maximum number of cycles spent waiting for a press; 0 disables the timeout.
- `HOLD_W`, 16: width of the hold-duration counter.
- `IDX_W`, `$clog2(N_BUTTONS)`: width of the button index (derived parameter).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `arm`  in  1  start-capture request; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; effective in any state except IDLE.
- `pressed`  in  N_BUTTONS  one-cycle press strobes; bit i = button i.
- `released`  in  N_BUTTONS  one-cycle release strobes.
- `busy`  out  1  high in WAIT_PRESS and WAIT_RELEASE.
- `captured_signal`  out  1  one-cycle strobe: a button was latched.
- `released_signal`  out  1  one-cycle strobe: the latched button was released.
- `timeout_signal`  out  1  one-cycle strobe: no press arrived within TIMEOUT_CYCLES.
- `button`  out  IDX_W  index of the last latched button; held until the next capture.
- `hold_cycles`  out  HOLD_W  number of cycles between capture and release, saturating; held until the next capture.

## Operation
- The FSM has three states: IDLE, WAIT_PRESS and WAIT_RELEASE. Reset state is IDLE.
- Reset values: all three strobes 0, `busy` 0, `button` 0, `hold_cycles` 0, wait counter 0.
- IDLE:
  - `arm`=1 → WAIT_PRESS, wait counter cleared.
  - `pressed`, `released` and `abort` are ignored.
- WAIT_PRESS:
  - If `pressed` is nonzero, `button` takes the lowest set bit index (bit 0 has the highest priority).
  - On that press, `hold_cycles` is cleared, `captured_signal` is pulsed and the FSM moves to WAIT_RELEASE.
  - Otherwise the wait counter increments. If TIMEOUT_CYCLES≠0 and the counter equals TIMEOUT_CYCLES-1, `timeout_signal` is pulsed and the FSM moves to IDLE; `button` is unchanged.
  - A press on the same cycle as the timeout boundary takes priority: capture, no timeout.
- WAIT_RELEASE:
  - If `released[button]` is set, `released_signal` is pulsed and the FSM moves to IDLE; `hold_cycles` is frozen.
  - Otherwise `hold_cycles` increments, saturating at 2^HOLD_W-1.
  - Further presses, and releases of other buttons, are ignored.
- `abort`=1 in WAIT_PRESS or WAIT_RELEASE → IDLE on the next edge with no strobes. `abort` has priority over a simultaneous press, release or timeout.
- Asserting `reset` mid-operation forces IDLE immediately and clears all outputs, including `button`.

## Timing
- All outputs are registered.
- A strobe is high for exactly the one cycle after the edge that detected its event.
- Arm latency: `arm` sampled at edge k → `busy`=1 from k+1. `pressed` is sampled first at edge k+1, so a press coincident with `arm` is lost.
- Capture latency: press sampled at edge k → `captured_signal` and new `button` visible after k.
- A release strobe is accepted from the first WAIT_RELEASE cycle, i.e. edge k+1 after the capture at edge k.
- Hold measurement: capture at edge k, release at edge k+1+h → `hold_cycles`=h.
- Timeout: `arm` at edge k, no press → `timeout_signal` high after edge k+TIMEOUT_CYCLES and `busy` falls at the same edge.
- Re-arm: `arm` can be accepted on the cycle IDLE is re-entered, i.e. the cycle a strobe is high. Back-to-back captures therefore need no dead cycle beyond the state transition.
- At most one of the three strobes is high in any cycle.

## Test plan
- Reset and basic capture (N_BUTTONS=4): assert reset, then `arm`; `pressed`=4'b0100 → `captured_signal` pulse, `button`=2; 3 cycles later `released`=4'b0100 → `released_signal` pulse, `hold_cycles`=2, `busy`=0.
- Priority and masking: `pressed`=4'b1010 → `button`=1. In WAIT_RELEASE, `released`=4'b1000 → no strobe. Then `released`=4'b0010 → `released_signal` pulse.
- Timeout (TIMEOUT_CYCLES=5): `arm`, no press → `timeout_signal` high exactly 5 cycles after the `arm` edge. Repeat with a press on the 5th wait cycle → `captured_signal`, no timeout.
- Abort and reset mid-operation: `abort` in WAIT_RELEASE together with the matching release → IDLE, no strobe. Async `reset` mid-WAIT_PRESS → outputs 0 before the next clock edge.
- Saturation (HOLD_W=3): hold the button for 20 cycles → `hold_cycles`=7.
- Generic width (N_BUTTONS=7): `pressed`=7'b1000000 → `button`=6. `arm` and press on the same cycle → press ignored.

Source files
------------

// File: rtl/simon_input_capture.sv
// simon_input_capture: arms on request, latches the highest-priority pressed button,
// and reports press/release strobes with a press timeout and a saturating hold measurement.
module simon_input_capture #(
    parameter int N_BUTTONS      = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int HOLD_W         = 16,
    parameter int IDX_W          = $clog2(N_BUTTONS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [N_BUTTONS-1:0] pressed,
    input  logic [N_BUTTONS-1:0] released,
    output logic                 busy,
    output logic                 captured_signal,
    output logic                 released_signal,
    output logic                 timeout_signal,
    output logic [IDX_W-1:0]     button,
    output logic [HOLD_W-1:0]    hold_cycles
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   button_q, button_d, pick;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               cap_q, cap_d, rel_q, rel_d, to_q, to_d;

    // Scanning downwards leaves the lowest set bit, which has the highest priority.
    always_comb begin
        pick = '0;
        for (int i = N_BUTTONS - 1; i >= 0; i--)
            if (pressed[i]) pick = IDX_W'(i);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        button_d = button_q;
        hold_d   = hold_q;
        cap_d    = 1'b0;
        rel_d    = 1'b0;
        to_d     = 1'b0;
        case (state_q)
            IDLE: if (arm) begin
                state_d = WAIT_PRESS;
                cnt_d   = '0;
            end
            WAIT_PRESS: if (abort) begin
                state_d = IDLE;
            end else if (|pressed) begin
                state_d  = WAIT_RELEASE;
                button_d = pick;
                hold_d   = '0;
                cap_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (TIMEOUT_CYCLES != 0 && cnt_q == T_LAST) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                end
            end
            WAIT_RELEASE: if (abort) begin
                state_d = IDLE;
            end else if (released[button_q]) begin
                state_d = IDLE;
                rel_d   = 1'b1;
            end else if (hold_q != '1) begin
                hold_d = hold_q + HOLD_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            button_q <= '0;
            hold_q   <= '0;
            cap_q    <= 1'b0;
            rel_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            button_q <= button_d;
            hold_q   <= hold_d;
            cap_q    <= cap_d;
            rel_q    <= rel_d;
            to_q     <= to_d;
        end
    end

    assign busy            = state_q != IDLE;
    assign captured_signal = cap_q;
    assign released_signal = rel_q;
    assign timeout_signal  = to_q;
    assign button          = button_q;
    assign hold_cycles     = hold_q;
endmodule

// File: tb/tb_simon_input_capture.sv
// tb_simon_input_capture: directed scenarios plus random traffic checked every cycle
// against a behavioural model of the capture rules.
module tb_simon_input_capture;
    localparam int N  = 7;
    localparam int T  = 5;
    localparam int HW = 3;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0, reset, arm, abort;
    logic [N-1:0]  pressed, released;
    logic          busy, captured_signal, released_signal, timeout_signal;
    logic [IW-1:0] button;
    logic [HW-1:0] hold_cycles;

    simon_input_capture #(.N_BUTTONS(N), .TIMEOUT_CYCLES(T), .HOLD_W(HW)) dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort),
        .pressed(pressed), .released(released), .busy(busy),
        .captured_signal(captured_signal), .released_signal(released_signal),
        .timeout_signal(timeout_signal), .button(button), .hold_cycles(hold_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit m_wait, m_hold, e_cap, e_rel, e_to;
    int m_waited, m_btn, m_hold_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_hold = 0; e_cap = 0; e_rel = 0; e_to = 0;
        m_waited = 0; m_btn = 0; m_hold_cnt = 0;
    endtask

    task automatic model(input bit a, input bit ab, input logic [N-1:0] p, input logic [N-1:0] r);
        int pi;
        e_cap = 0; e_rel = 0; e_to = 0;
        if (!m_wait && !m_hold) begin
            if (a) begin m_wait = 1; m_waited = 0; end
        end else if (ab) begin
            m_wait = 0; m_hold = 0;
        end else if (m_wait) begin
            if (p != 0) begin
                pi = int'(p);
                m_btn = $clog2(pi & -pi);
                m_hold_cnt = 0; e_cap = 1; m_wait = 0; m_hold = 1;
            end else begin
                m_waited++;
                if (m_waited == T) begin e_to = 1; m_wait = 0; end
            end
        end else if (r[m_btn]) begin
            e_rel = 1; m_hold = 0;
        end else begin
            m_hold_cnt = (m_hold_cnt + 1 > (1 << HW) - 1) ? (1 << HW) - 1 : m_hold_cnt + 1;
        end
    endtask

    task automatic compare_all();
        check("busy", busy, m_wait | m_hold);
        check("captured", captured_signal, e_cap);
        check("released", released_signal, e_rel);
        check("timeout", timeout_signal, e_to);
        check("button", button, m_btn);
        check("hold", hold_cycles, m_hold_cnt);
    endtask

    task automatic step(input bit a, input bit ab, input logic [N-1:0] p, input logic [N-1:0] r);
        arm = a; abort = ab; pressed = p; released = r;
        @(posedge clk);
        model(a, ab, p, r);
        #1 compare_all();
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        model_reset();
        #1 compare_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; arm = 0; abort = 0; pressed = '0; released = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        reset = 1'b0;

        // basic capture and hold of 2
        step(1, 0, 7'b0000000, '0);
        step(0, 0, 7'b0000100, '0);
        check("cap_button2", button, 2);
        step(0, 0, '0, '0);
        step(0, 0, '0, '0);
        step(0, 0, '0, 7'b0000100);
        check("hold2", hold_cycles, 2);
        check("idle_after_rel", busy, 0);

        // priority and release masking
        step(1, 0, '0, '0);
        step(0, 0, 7'b0001010, '0);
        check("prio_button1", button, 1);
        step(0, 0, '0, 7'b0001000);
        step(0, 0, 7'b0000001, 7'b0001000);
        step(0, 0, '0, 7'b0000010);

        // timeout exactly T cycles after arm
        step(1, 0, '0, '0);
        for (int i = 1; i < T; i++) step(0, 0, '0, '0);
        step(0, 0, '0, '0);
        check("timeout_at_T", timeout_signal, 1);

        // press on the boundary cycle wins; re-arm on the strobe cycle
        step(1, 0, '0, '0);
        for (int i = 1; i < T; i++) step(0, 0, '0, '0);
        step(0, 0, 7'b0010000, '0);
        check("boundary_cap", captured_signal, 1);
        check("boundary_no_to", timeout_signal, 0);
        step(0, 0, '0, 7'b0010000);
        step(1, 0, '0, '0);
        check("rearm_busy", busy, 1);

        // abort with matching release: no strobe
        step(0, 0, 7'b0100000, '0);
        step(0, 1, '0, 7'b0100000);
        check("abort_no_rel", released_signal, 0);

        // async reset mid-WAIT_PRESS
        step(1, 0, '0, '0);
        step(0, 0, '0, '0);
        async_reset();

        // hold saturation
        step(1, 0, '0, '0);
        step(0, 0, 7'b1000000, '0);
        check("button6", button, 6);
        for (int i = 0; i < 20; i++) step(0, 0, '0, '0);
        step(0, 0, '0, 7'b1000000);
        check("hold_sat", hold_cycles, 7);

        // arm with coincident press: press lost
        step(1, 0, 7'b0000001, '0);
        check("arm_press_lost", captured_signal, 0);
        step(0, 1, '0, '0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) async_reset();
            else step($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
                      ($urandom_range(0, 5) == 0) ? N'($urandom) : '0,
                      ($urandom_range(0, 3) == 0) ? N'($urandom) : '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
